// File: rtl/mlp_loader_pkg.sv
// Shared state type, default geometry and bias-field offsets for the MLP parameter loader.
// Frame length grows by one trailing sum byte when MLP_LOADER_CHECKSUM_EN is defined.
package mlp_loader_pkg;

  typedef enum logic [2:0] {LOAD_W, LOAD_B, CSUM, COMMIT, DRAIN} state_t;

  localparam int DEF_N_W     = 72;
  localparam int DEF_W_BITS  = 8;
  localparam int DEF_N_B0    = 3;
  localparam int DEF_B0_BITS = 12;
  localparam int DEF_N_B1    = 3;
  localparam int DEF_B1_BITS = 13;

  localparam int N_PAYLOAD_BYTES = DEF_N_W + 2 * (DEF_N_B0 + DEF_N_B1);
`ifdef MLP_LOADER_CHECKSUM_EN
  localparam int N_FRAME_BYTES = N_PAYLOAD_BYTES + 1;
`else
  localparam int N_FRAME_BYTES = N_PAYLOAD_BYTES;
`endif
  localparam int BIAS_W_TOTAL   = DEF_N_B0 * DEF_B0_BITS + DEF_N_B1 * DEF_B1_BITS;
  localparam int L1_BIAS_OFFSET = DEF_N_B0 * DEF_B0_BITS;

  // Layer-0 fields are packed first, layer-1 fields follow contiguously.
  function automatic int bias_lsb(input int idx, input int n_b0, input int b0_bits,
                                  input int b1_bits);
    return (idx < n_b0) ? idx * b0_bits : n_b0 * b0_bits + (idx - n_b0) * b1_bits;
  endfunction

endpackage

// File: rtl/mlp_param_loader.sv
// Byte-stream writer for the MLP core's weights/biases buses; shadow set is committed atomically.
// Define MLP_LOADER_CHECKSUM_EN to require a trailing mod-256 payload sum byte before commit.
module mlp_param_loader
  import mlp_loader_pkg::*;
#(
  parameter int N_W     = DEF_N_W,
  parameter int W_BITS  = DEF_W_BITS,
  parameter int N_B0    = DEF_N_B0,
  parameter int B0_BITS = DEF_B0_BITS,
  parameter int N_B1    = DEF_N_B1,
  parameter int B1_BITS = DEF_B1_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [7:0]                           in_data,
  input  logic                                 in_last,
  output logic [N_W*W_BITS-1:0]                weights,
  output logic [N_B0*B0_BITS+N_B1*B1_BITS-1:0] biases,
  output logic                                 params_valid,
  output logic                                 load_done,
  output logic                                 load_err
);

  localparam int N_B   = N_B0 + N_B1;
  localparam int N_PAY = N_W + 2 * N_B;
`ifdef MLP_LOADER_CHECKSUM_EN
  localparam int N_FRAME = N_PAY + 1;
`else
  localparam int N_FRAME = N_PAY;
`endif
  localparam int CNT_W = $clog2(N_FRAME + 1);
  localparam int BW    = N_B0 * B0_BITS + N_B1 * B1_BITS;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [N_W*W_BITS-1:0] shadow_w;
  logic [16*N_B-1:0]   shadow_b;
  logic [16*N_B-1:0]   shadow_b_nxt;
  logic [BW-1:0]       packed_b;
  logic                accept;
  logic                last_w;
  logic                last_pay;
  logic                early;
  logic                fin_ok;
  logic                fin_no_last;
  logic                fin_bad;

  assign accept   = in_valid && in_ready;
  assign last_w   = (count == CNT_W'(N_W - 1));
  assign last_pay = (count == CNT_W'(N_PAY - 1));
  assign early    = in_last && (count != CNT_W'(N_FRAME - 1));

  // Merge the byte being accepted so the commit edge sees the complete bias set.
  always_comb begin
    shadow_b_nxt = shadow_b;
    if (accept && state == LOAD_B)
      shadow_b_nxt[(int'(count) - N_W) * 8 +: 8] = in_data;
  end

  for (genvar j = 0; j < N_B; j++) begin : g_pack
    localparam int FW = (j < N_B0) ? B0_BITS : B1_BITS;
    assign packed_b[bias_lsb(j, N_B0, B0_BITS, B1_BITS) +: FW] = shadow_b_nxt[16*j +: FW];
  end

`ifdef MLP_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      csum <= '0;
    else if (accept) begin
      if ((state == LOAD_W || state == LOAD_B) && !early)
        csum <= csum + in_data;
      else
        csum <= '0;
    end
  end

  assign fin_ok      = accept && state == CSUM && in_last && (csum == in_data);
  assign fin_bad     = accept && state == CSUM && in_last && (csum != in_data);
  assign fin_no_last = accept && state == CSUM && !in_last;
`else
  assign fin_ok      = accept && state == LOAD_B && last_pay && in_last;
  assign fin_bad     = 1'b0;
  assign fin_no_last = accept && state == LOAD_B && last_pay && !in_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD_W;
      count        <= '0;
      shadow_w     <= '0;
      shadow_b     <= '0;
      weights      <= '0;
      biases       <= '0;
      params_valid <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      in_ready  <= 1'b1;
      if (fin_ok) begin
        weights      <= shadow_w;
        biases       <= packed_b;
        params_valid <= 1'b1;
        load_done    <= 1'b1;
        in_ready     <= 1'b0;
        shadow_b     <= shadow_b_nxt;
        count        <= '0;
        state        <= COMMIT;
      end else if (fin_no_last) begin
        load_err <= 1'b1;
        count    <= count + 1'b1;
        state    <= DRAIN;
      end else if (fin_bad) begin
        load_err <= 1'b1;
        shadow_w <= '0;
        shadow_b <= '0;
        count    <= '0;
        state    <= LOAD_W;
      end else begin
        case (state)
          LOAD_W, LOAD_B: if (accept) begin
            if (early) begin
              load_err <= 1'b1;
              shadow_w <= '0;
              shadow_b <= '0;
              count    <= '0;
              state    <= LOAD_W;
            end else begin
              count <= count + 1'b1;
              if (state == LOAD_W) begin
                shadow_w[int'(count) * W_BITS +: W_BITS] <= in_data[W_BITS-1:0];
                if (last_w) state <= LOAD_B;
              end else begin
                shadow_b <= shadow_b_nxt;
`ifdef MLP_LOADER_CHECKSUM_EN
                if (last_pay) state <= CSUM;
`endif
              end
            end
          end
          CSUM: ;
          COMMIT: state <= LOAD_W;
          DRAIN: if (accept) begin
            if (in_last) begin
              shadow_w <= '0;
              shadow_b <= '0;
              count    <= '0;
              state    <= LOAD_W;
            end else if (count != '1) begin
              count <= count + 1'b1;
            end
          end
          default: state <= LOAD_W;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlp_param_loader.sv
// Scoreboard bench for mlp_param_loader: stimulus queues expected commit/error events and
// a separate monitor checks them whenever load_done or load_err pulses.
`timescale 1ns/1ps
module tb_mlp_param_loader;
  import mlp_loader_pkg::*;

  localparam int WW        = DEF_N_W * DEF_W_BITS;
  localparam int BW        = BIAS_W_TOTAL;
  localparam int FRAME_LEN = N_FRAME_BYTES;

  // Raw 16-bit little-endian bias words as sent, bias 0 in the low word.
  localparam logic [95:0] RAW_A = {16'hF7AD, 16'h0386, 16'hF9F5, 16'h0435, 16'h02EC, 16'hFFB7};
  localparam logic [95:0] RAW_B = {16'h7FFF, 16'h0FFF, 16'hF000, 16'h07FF, 16'hFFFF, 16'h0001};
  // Hand-truncated packed fields: -73,748,1077 (12b) and -1547,902,-2131 (13b).
  localparam logic [BW-1:0] BIAS_A = {13'h17AD, 13'h0386, 13'h19F5, 12'h435, 12'h2EC, 12'hFB7};
  localparam logic [BW-1:0] BIAS_B = {13'h1FFF, 13'h0FFF, 13'h1000, 12'h7FF, 12'hFFF, 12'h001};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          params_valid;
  logic          load_done;
  logic          load_err;
  logic [WW-1:0] weights;
  logic [BW-1:0] biases;

  mlp_param_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .weights(weights), .biases(biases),
    .params_valid(params_valid), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            done;
    logic [WW-1:0] w;
    logic [BW-1:0] b;
    bit            pv;
  } exp_t;

  exp_t          q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  logic [WW-1:0] cur_w = '0;
  logic [BW-1:0] cur_b = '0;
  bit            cur_pv = 1'b0;

  task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] wbyte(input int set, input int k);
    if (set == 0) begin
      case (k)
        0, 1:    return 8'h00;
        2:       return 8'h02;
        3:       return 8'hFD;
        default: return 8'((k * 37 + 5) % 256);
      endcase
    end
    return 8'((k * 11 + 3) % 256);
  endfunction

  function automatic logic [7:0] payload_byte(input int set, input int i);
    logic [95:0] raw;
    raw = (set == 0) ? RAW_A : RAW_B;
    if (i < DEF_N_W) return wbyte(set, i);
    return raw[8*(i - DEF_N_W) +: 8];
  endfunction

  function automatic logic [7:0] frame_byte(input int set, input int i);
    logic [7:0] s;
    if (i < N_PAYLOAD_BYTES) return payload_byte(set, i);
    s = 8'h00;
    for (int k = 0; k < N_PAYLOAD_BYTES; k++) s = s + payload_byte(set, k);
    return s;
  endfunction

  function automatic logic [WW-1:0] exp_w(input int set);
    logic [WW-1:0] w;
    for (int k = 0; k < DEF_N_W; k++) w[8*k +: 8] = wbyte(set, k);
    return w;
  endfunction

  task automatic expect_done(input int set);
    exp_t e;
    e.done = 1'b1;
    e.w    = exp_w(set);
    e.b    = (set == 0) ? BIAS_A : BIAS_B;
    e.pv   = 1'b1;
    q.push_back(e);
    cur_w = e.w;
    cur_b = e.b;
    cur_pv = 1'b1;
  endtask

  task automatic expect_err();
    exp_t e;
    e.done = 1'b0;
    e.w    = cur_w;
    e.b    = cur_b;
    e.pv   = cur_pv;
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge right after the byte was accepted.
  task automatic send(input logic [7:0] b, input bit last, input int gap);
    int t;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: got in_ready=0 for %0d cycles want 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int set, input int n, input int last_at, input bit gaps,
                            input bit bad_sum);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = frame_byte(set, i);
      if (bad_sum && i == N_PAYLOAD_BYTES) b = b + 8'd1;
      send(b, (i + 1) == last_at, (gaps && i > 0) ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (load_done || load_err)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_event: got done=%0b err=%0b want no event", load_done, load_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("event_done", load_done, e.done);
        check("event_err", load_err, !e.done);
        check("event_weights", weights, e.w);
        check("event_biases", biases, e.b);
        check("event_params_valid", params_valid, e.pv);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_weights", weights, '0);
    check("rst_biases", biases, '0);
    check("rst_params_valid", params_valid, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1 check("release_in_ready_hold", in_ready, 1'b0);
    @(negedge clk);
    check("release_in_ready", in_ready, 1'b1);

    expect_done(0);
    send_frame(0, FRAME_LEN, FRAME_LEN, 1'b0, 1'b0);
    check("commit_load_done", load_done, 1'b1);
    check("commit_in_ready_low", in_ready, 1'b0);
    check("commit_weight2", weights[23:16], 8'h02);
    check("commit_bias0", biases[11:0], 12'hFB7);
    check("commit_params_valid", params_valid, 1'b1);

    // First byte lands during the COMMIT cycle.
    expect_done(1);
    send_frame(1, FRAME_LEN, FRAME_LEN, 1'b1, 1'b0);
    expect_done(0);
    send_frame(0, FRAME_LEN, FRAME_LEN, 1'b1, 1'b0);
    check("gaps_weights", weights, exp_w(0));
    check("gaps_biases", biases, BIAS_A);

    expect_err();
    send_frame(1, 40, 40, 1'b0, 1'b0);
    check("early_err_pulse", load_err, 1'b1);
    check("early_hold_weights", weights, exp_w(0));
    check("early_hold_biases", biases, BIAS_A);
    expect_done(1);
    send_frame(1, FRAME_LEN, FRAME_LEN, 1'b0, 1'b0);

    expect_err();
    send_frame(0, FRAME_LEN, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 4, 0);
    check("drain_hold_weights", weights, exp_w(1));
    check("drain_hold_biases", biases, BIAS_B);
    expect_done(0);
    send_frame(0, FRAME_LEN, FRAME_LEN, 1'b0, 1'b0);

`ifdef MLP_LOADER_CHECKSUM_EN
    expect_done(1);
    send_frame(1, FRAME_LEN, FRAME_LEN, 1'b0, 1'b0);
    expect_err();
    send_frame(0, FRAME_LEN, FRAME_LEN, 1'b0, 1'b1);
    check("bad_sum_hold_weights", weights, exp_w(1));
`else
    expect_err();
    send_frame(1, N_PAYLOAD_BYTES + 1, N_PAYLOAD_BYTES + 1, 1'b0, 1'b0);
    check("len85_hold_weights", weights, exp_w(0));
`endif

    send_frame(0, 50, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_weights", weights, '0);
    check("async_rst_biases", biases, '0);
    check("async_rst_params_valid", params_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b0);
    cur_w = '0;
    cur_b = '0;
    cur_pv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerelease_in_ready", in_ready, 1'b1);
    expect_done(1);
    send_frame(1, FRAME_LEN, FRAME_LEN, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
